// File: rtl/stage_ex.sv
// stage_ex: execute stage with single-cycle ALU, load/store address generation and
// EX/MM output registers. Defining EX_MULDIV_EN builds the iterative mul/div unit and its FSM.
module stage_ex #(
  parameter int DATA_W            = 32,
  parameter int REG_ADDR_W        = 5,
  parameter int DATA_ADDR_W       = 32,
  parameter int MD_BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [3:0]             alu_op,
  input  logic [DATA_W-1:0]      op_a,
  input  logic [DATA_W-1:0]      op_b,
  input  logic [DATA_W-1:0]      store_data,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic                   is_atomic,
  input  logic                   reg_wr,
  input  logic [REG_ADDR_W-1:0]  reg_addr_rd,
  output logic                   ex_busy,
  output logic [DATA_W-1:0]      ffw_EX_data,
  output logic                   out_is_load,
  output logic                   out_is_store,
  output logic                   out_is_atomic,
  output logic                   out_reg_wr,
  output logic [REG_ADDR_W-1:0]  out_reg_addr_rd,
  output logic [DATA_W-1:0]      out_reg_data_rd,
  output logic [DATA_ADDR_W-1:0] out_alu_mem_addr,
  output logic                   out_flush
);
  localparam int SHW   = $clog2(DATA_W);
  localparam int FLD_W = REG_ADDR_W + 4;

  logic signed [DATA_W-1:0] a_s, b_s;
  logic [SHW-1:0]           shamt;
  logic [DATA_W-1:0]        sc_res;

  assign a_s   = op_a;
  assign b_s   = op_b;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    sc_res = '0;
    case (alu_op)
      4'd0:    sc_res = op_a + op_b;
      4'd1:    sc_res = op_a - op_b;
      4'd2:    sc_res = op_a & op_b;
      4'd3:    sc_res = op_a | op_b;
      4'd4:    sc_res = op_a ^ op_b;
      4'd5:    sc_res = op_a << shamt;
      4'd6:    sc_res = op_a >> shamt;
      4'd7:    sc_res = a_s >>> shamt;
      4'd8:    sc_res = {{(DATA_W-1){1'b0}}, a_s < b_s};
      4'd9:    sc_res = {{(DATA_W-1){1'b0}}, op_a < op_b};
      4'd15:   sc_res = op_b;
      default: sc_res = '0;
    endcase
  end

  assign ffw_EX_data = sc_res;

  logic              bubble, md_out;
  logic [DATA_W-1:0] md_res;
  logic [FLD_W-1:0]  md_fld_q;

`ifdef EX_MULDIV_EN
  localparam int N     = DATA_W / MD_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              md_req, md_iss, md_ld;
  logic [DATA_W-1:0] acc_q, qr_q, b_q, acc_t, qr_t, b_t;
  logic [DATA_W:0]   rem_t;
  logic [3:0]        op_q;
  logic              neg_q_q, neg_r_q, dz_q, iss_mul, iss_sgn;

  assign md_req  = (alu_op >= 4'd10) && (alu_op <= 4'd14) && !flush;
  assign iss_mul = (alu_op == 4'd10);
  assign iss_sgn = (alu_op == 4'd11) || (alu_op == 4'd13);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_iss  = 1'b0;
    md_ld   = 1'b0;
    bubble  = 1'b0;
    md_out  = 1'b0;
    case (state_q)
      IDLE: if (md_req) begin
        bubble = 1'b1;
        if (en) begin
          md_iss  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_W'(N);
        end
      end
      BUSY: begin
        bubble = 1'b1;
        if (en && flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (en) begin
          md_ld = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: if (flush) begin
        bubble = 1'b1;
        if (en) state_d = IDLE;
      end else begin
        md_out = 1'b1;
        if (en && !stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ex_busy = ((state_q == IDLE) && md_req) ||
                   (!flush && ((state_q == BUSY) || ((state_q == DONE) && (stall || !en))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shift-add multiply and restoring divide share acc/qr/b; MD_BITS_PER_CYCLE steps per edge.
  always_comb begin
    acc_t = acc_q;
    qr_t  = qr_q;
    b_t   = b_q;
    rem_t = {1'b0, acc_q};
    for (int i = 0; i < MD_BITS_PER_CYCLE; i++) begin
      if (op_q == 4'd10) begin
        if (qr_t[0]) acc_t = acc_t + b_t;
        b_t  = b_t << 1;
        qr_t = qr_t >> 1;
      end else begin
        rem_t = {rem_t[DATA_W-1:0], qr_t[DATA_W-1]};
        qr_t  = qr_t << 1;
        if (rem_t >= {1'b0, b_q}) begin
          rem_t   = rem_t - {1'b0, b_q};
          qr_t[0] = 1'b1;
        end
      end
    end
    if (op_q != 4'd10) acc_t = rem_t[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (md_iss) begin
      acc_q    <= '0;
      qr_q     <= (!iss_mul && iss_sgn && op_a[DATA_W-1]) ? -op_a : op_a;
      b_q      <= (!iss_mul && iss_sgn && op_b[DATA_W-1]) ? -op_b : op_b;
      op_q     <= alu_op;
      neg_q_q  <= iss_sgn && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
      neg_r_q  <= iss_sgn && op_a[DATA_W-1];
      dz_q     <= (op_b == '0);
      md_fld_q <= {is_load, is_store, is_atomic, reg_wr, reg_addr_rd};
    end else if (md_ld) begin
      acc_q <= acc_t;
      qr_q  <= qr_t;
      b_q   <= b_t;
    end
  end

  // Magnitudes were divided; signs restored here. Divide by zero leaves remainder = dividend.
  always_comb begin
    case (op_q)
      4'd10:        md_res = acc_q;
      4'd11, 4'd12: md_res = dz_q ? '1 : (neg_q_q ? -qr_q : qr_q);
      default:      md_res = neg_r_q ? -acc_q : acc_q;
    endcase
  end
`else
  assign ex_busy  = 1'b0;
  assign bubble   = 1'b0;
  assign md_out   = 1'b0;
  assign md_res   = '0;
  assign md_fld_q = '0;
`endif

  logic                   ld, flush_d;
  logic [FLD_W-1:0]       fld_d;
  logic [DATA_W-1:0]      data_d;
  logic [DATA_ADDR_W-1:0] addr_d;
  logic [FLD_W-1:0]       fld_q;
  logic [DATA_W-1:0]      data_q;
  logic [DATA_ADDR_W-1:0] addr_q;
  logic                   flush_q;

  assign ld = en && !stall;

  always_comb begin
    flush_d = flush;
    fld_d   = {is_load, is_store, is_atomic, reg_wr, reg_addr_rd};
    data_d  = is_store ? store_data : sc_res;
    addr_d  = sc_res[DATA_ADDR_W-1:0];
    if (bubble) begin
      flush_d = 1'b1;
      fld_d   = {4'b0000, fld_q[REG_ADDR_W-1:0]};
      data_d  = data_q;
      addr_d  = addr_q;
    end else if (md_out) begin
      flush_d = 1'b0;
      fld_d   = md_fld_q;
      data_d  = md_res;
      addr_d  = md_res[DATA_ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= 1'b1;
      fld_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else if (ld) begin
      flush_q <= flush_d;
      fld_q   <= fld_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign out_flush        = flush_q;
  assign out_is_load      = fld_q[REG_ADDR_W+3];
  assign out_is_store     = fld_q[REG_ADDR_W+2];
  assign out_is_atomic    = fld_q[REG_ADDR_W+1];
  assign out_reg_wr       = fld_q[REG_ADDR_W];
  assign out_reg_addr_rd  = fld_q[REG_ADDR_W-1:0];
  assign out_reg_data_rd  = data_q;
  assign out_alu_mem_addr = addr_q;
endmodule

// File: tb/tb_stage_ex.sv
// Scoreboard bench for stage_ex: a driver pushes expected EX/MM results from a
// behavioural model; a monitor pops and compares on every non-bubble output load.
module tb_stage_ex;
  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int AW  = 32;
  localparam int N   = 32;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0]     alu_op = '0;
  logic [DW-1:0]  op_a = '0, op_b = '0, store_data = '0;
  logic           is_load = 1'b0, is_store = 1'b0, is_atomic = 1'b0, reg_wr = 1'b0;
  logic [RAW-1:0] reg_addr_rd = '0;
  logic           ex_busy, out_is_load, out_is_store, out_is_atomic, out_reg_wr, out_flush;
  logic [DW-1:0]  ffw_EX_data, out_reg_data_rd;
  logic [RAW-1:0] out_reg_addr_rd;
  logic [AW-1:0]  out_alu_mem_addr;

  stage_ex #(.DATA_W(DW), .REG_ADDR_W(RAW), .DATA_ADDR_W(AW), .MD_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush), .alu_op(alu_op),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .is_load(is_load),
    .is_store(is_store), .is_atomic(is_atomic), .reg_wr(reg_wr), .reg_addr_rd(reg_addr_rd),
    .ex_busy(ex_busy), .ffw_EX_data(ffw_EX_data), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_is_atomic(out_is_atomic), .out_reg_wr(out_reg_wr),
    .out_reg_addr_rd(out_reg_addr_rd), .out_reg_data_rd(out_reg_data_rd),
    .out_alu_mem_addr(out_alu_mem_addr), .out_flush(out_flush));

  always #5 clk = ~clk;

  typedef struct packed {
    logic ld, st, at, wr;
    logic [RAW-1:0] rd;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0, fails = 0, bub_cnt = 0, res_cnt = 0;
  bit ld_pend = 1'b0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  function automatic logic [DW-1:0] ref_res(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return sa >>> b[4:0];
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd15: return b;
`ifdef EX_MULDIV_EN
      4'd10: return a * b;
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : sa / sb);
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : (ovf ? 32'd0 : sa % sb);
      4'd14: return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] op, input logic [DW-1:0] a, b, sd,
                                  input logic ld, st, at, wr, input logic [RAW-1:0] rd);
    exp_t e;
    logic [DW-1:0] r;
    r = ref_res(op, a, b);
    e.ld = ld; e.st = st; e.at = at; e.wr = wr; e.rd = rd;
    e.data = st ? sd : r;
    e.addr = r[AW-1:0];
    return e;
  endfunction

  // Monitor: a load happens on every edge with en && !stall; non-bubble loads are results.
  always @(posedge clk) ld_pend = rst_n && en && !stall;

  always @(negedge clk) begin
    exp_t e;
    if (ld_pend) begin
      if (out_flush) bub_cnt++;
      else if (exp_q.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        e = exp_q.pop_front();
        res_cnt++;
        chk("sb_result", {out_is_load, out_is_store, out_is_atomic, out_reg_wr,
                          out_reg_addr_rd, out_reg_data_rd, out_alu_mem_addr}, e);
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, b, sd,
                       input logic ld, st, at, wr, fl, input logic [RAW-1:0] rd);
    alu_op = op; op_a = a; op_b = b; store_data = sd;
    is_load = ld; is_store = st; is_atomic = at; reg_wr = wr; flush = fl; reg_addr_rd = rd;
  endtask

  // Called at a negedge; holds the instruction until EX accepts it, returns at a negedge.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, b, sd,
                       input logic ld, st, at, wr, fl, input logic [RAW-1:0] rd,
                       input bit rnd, output int occ);
    bit acc;
    drive(op, a, b, sd, ld, st, at, wr, fl, rd);
    if (!fl) exp_q.push_back(mk_exp(op, a, b, sd, ld, st, at, wr, rd));
    acc = 1'b0;
    occ = 0;
    while (!acc && occ < 600) begin
      if (rnd) begin
        en    = ($urandom_range(0, 9) != 0);
        stall = ($urandom_range(0, 4) == 0);
      end else begin
        en = 1'b1; stall = 1'b0;
      end
      #4;
      if (occ == 0 && (op < 4'd10 || op == 4'd15)) chk("ffw", ffw_EX_data, ref_res(op, a, b));
      acc = !ex_busy && en && !stall;
      @(posedge clk);
      @(negedge clk);
      occ++;
    end
    if (!acc) fail_now("issue_timeout");
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ, r0;
    logic [3:0] op;
    logic [DW-1:0] a, b, snap;
    logic st;

    repeat (2) @(negedge clk);
    chk("rst_flush", out_flush, 1);
    chk("rst_flags", {out_is_load, out_is_store, out_is_atomic, out_reg_wr}, 0);
    chk("rst_rd", out_reg_addr_rd, 0);
    chk("rst_data", out_reg_data_rd, 0);
    chk("rst_addr", out_alu_mem_addr, 0);
    chk("rst_busy", ex_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 1, 0, 5'd3, 0, occ);
    chk("add_latency", occ, 1);
    chk("add_data", out_reg_data_rd, 32'h8000_0000);
    issue(4'd7, 32'h8000_0000, 32'd4, 0, 0, 0, 0, 1, 0, 5'd4, 0, occ);
    chk("sra_data", out_reg_data_rd, 32'hF800_0000);
    issue(4'd9, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 5'd5, 0, occ);
    chk("sltu_data", out_reg_data_rd, 32'd1);
    issue(4'd0, 32'h1000, 32'h24, 32'hCAFE_F00D, 0, 1, 0, 0, 0, 5'd0, 0, occ);
    chk("store_data", out_reg_data_rd, 32'hCAFE_F00D);
    chk("store_addr", out_alu_mem_addr, 32'h1024);
    issue(4'd0, 32'd10, 32'd20, 0, 0, 0, 0, 1, 1, 5'd9, 0, occ);
    chk("flushed_pass_flush", out_flush, 1);
    chk("flushed_pass_rd", out_reg_addr_rd, 9);
    chk("flushed_pass_data", out_reg_data_rd, 30);

`ifdef EX_MULDIV_EN
    bub_cnt = 0;
    issue(4'd11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 1, 0, 5'd6, 0, occ);
    chk("div_occupancy", occ, N + 2);
    chk("div_bubbles", bub_cnt, N + 1);
    chk("div_data", out_reg_data_rd, 32'hFFFF_FFFD);
    chk("div_wr", out_reg_wr, 1);
    issue(4'd13, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 1, 0, 5'd6, 0, occ);
    chk("rem_data", out_reg_data_rd, 32'hFFFF_FFFF);
    issue(4'd12, 32'd5, 32'd0, 0, 0, 0, 0, 1, 0, 5'd7, 0, occ);
    chk("divu_zero", out_reg_data_rd, 32'hFFFF_FFFF);
    issue(4'd14, 32'd5, 32'd0, 0, 0, 0, 0, 1, 0, 5'd7, 0, occ);
    chk("remu_zero", out_reg_data_rd, 32'd5);
    issue(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 5'd8, 0, occ);
    chk("div_ovf", out_reg_data_rd, 32'h8000_0000);
    issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 5'd8, 0, occ);
    chk("rem_ovf", out_reg_data_rd, 32'd0);

    // flush raised 10 iterations into a MUL
    drive(4'd10, 32'd1234, 32'd5678, 0, 0, 0, 0, 1, 0, 5'd10);
    en = 1'b1; stall = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_busy_drop", ex_busy, 0);
    @(negedge clk);
    chk("flush_bubble", out_flush, 1);
    issue(4'd15, 0, 32'h55, 0, 0, 0, 0, 0, 0, 5'd11, 0, occ);
    chk("flush_idle_next", occ, 1);

    // stall held for 3 cycles while DONE
    drive(4'd10, 32'h1_0000, 32'h1_0000, 0, 0, 0, 0, 1, 0, 5'd12);
    exp_q.push_back(mk_exp(4'd10, 32'h1_0000, 32'h1_0000, 0, 0, 0, 0, 1, 5'd12));
    en = 1'b1; stall = 1'b0;
    repeat (N + 1) @(negedge clk);
    stall = 1'b1;
    snap = out_reg_data_rd;
    r0 = res_cnt;
    for (int i = 0; i < 3; i++) begin
      #4 chk("stall_done_busy", ex_busy, 1);
      @(negedge clk);
      chk("stall_frozen_flush", out_flush, 1);
      chk("stall_frozen_data", out_reg_data_rd, snap);
    end
    stall = 1'b0;
    #4 chk("stall_release_busy", ex_busy, 0);
    @(negedge clk);
    drive(4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
    chk("mul_wr", out_reg_wr, 1);
    chk("mul_data", out_reg_data_rd, 0);
    repeat (2) @(negedge clk);
    chk("mul_once", res_cnt - r0, 1);
`else
    issue(4'd11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 1, 0, 5'd6, 0, occ);
    chk("md_off_latency", occ, 1);
    chk("md_off_data", out_reg_data_rd, 0);
    chk("md_off_busy", ex_busy, 0);
`endif

    // asynchronous reset mid-operation
    issue(4'd15, 0, 32'hA5A5_5A5A, 0, 0, 0, 0, 1, 0, 5'd13, 0, occ);
`ifdef EX_MULDIV_EN
    drive(4'd11, 32'd100, 32'd3, 0, 0, 0, 0, 1, 0, 5'd14);
    en = 1'b1; stall = 1'b0;
    repeat (6) @(negedge clk);
`else
    en = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flush", out_flush, 1);
    chk("arst_flags", {out_is_load, out_is_store, out_is_atomic, out_reg_wr}, 0);
    chk("arst_rd", out_reg_addr_rd, 0);
    chk("arst_data", out_reg_data_rd, 0);
    chk("arst_addr", out_alu_mem_addr, 0);
    alu_op = 4'd0;
    #1 chk("arst_idle", ex_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 32'd40, 32'd2, 0, 0, 0, 0, 1, 0, 5'd15, 0, occ);
    chk("post_rst_add", out_reg_data_rd, 42);

    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op >= 4'd10 && op <= 4'd14 && $urandom_range(0, 2) != 0) op = 4'($urandom_range(0, 9));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(0, 40);
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      st = (op >= 4'd10 && op <= 4'd14) ? 1'b0 : 1'($urandom_range(0, 1));
      issue(op, a, b, $urandom, 1'($urandom_range(0, 1)), st, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)), 1, occ);
    end

    drive(4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
    en = 1'b1; stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
